// File: rtl/mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stall_ctrl
// Description : Sequences MEM-stage loads/stores onto a 16-bit external SRAM.
//               Each 32-bit access is split into a low and a high half-word
//               phase of SRAM_WAIT cycles each. ready is combinational and
//               stalls the pipeline while an access is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stall_ctrl #(
   parameter int unsigned BASE_ADDR = 1024,
   parameter int unsigned SRAM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ST_Val,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   input  logic [15:0] SRAM_DQ_in,
   output logic        SRAM_WE_N
);

   localparam int unsigned c_CNT_W = $clog2(SRAM_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [16:0]          r_word;
   logic [31:0]          r_st_val;
   logic                 r_is_write;
   logic [31:0]          r_read_data;

   logic                 w_req;
   logic                 w_last;
   logic [31:0]          w_offset;
   logic [16:0]          w_word;
   logic                 w_unused_bits;

   // Byte offset into the SRAM window; only the word index is kept, the
   // byte-lane bits and anything above the 512 KiB window are dropped.
   assign w_offset      = ALU_result - 32'(BASE_ADDR);
   assign w_word        = w_offset[18:2];
   assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

   assign w_req     = MEM_R_EN | MEM_W_EN;
   assign w_last    = (r_cnt == c_CNT_W'(SRAM_WAIT - 1));
   assign read_data = r_read_data;

   // State register; reset aborts any access in flight immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and SRAM pin / ready outputs, all derived from state.
   always_comb begin
      w_next_state = r_state;
      ready        = 1'b0;
      SRAM_ADDR    = 18'd0;
      SRAM_DQ_out  = 16'd0;
      SRAM_DQ_oe   = 1'b0;
      SRAM_WE_N    = 1'b1;
      case (r_state)
         S_IDLE: begin
            ready = ~w_req;
            if (w_req) begin
               w_next_state = S_LO;
            end
         end
         S_LO: begin
            SRAM_ADDR = {r_word, 1'b0};
            if (r_is_write) begin
               SRAM_WE_N   = 1'b0;
               SRAM_DQ_oe  = 1'b1;
               SRAM_DQ_out = r_st_val[15:0];
            end
            if (w_last) begin
               w_next_state = S_HI;
            end
         end
         S_HI: begin
            SRAM_ADDR = {r_word, 1'b1};
            if (r_is_write) begin
               SRAM_WE_N   = 1'b0;
               SRAM_DQ_oe  = 1'b1;
               SRAM_DQ_out = r_st_val[31:16];
            end
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            // Enables still visible here belong to the access just finished.
            ready        = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Request latch, phase counter and load-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_word      <= '0;
         r_st_val    <= '0;
         r_is_write  <= 1'b0;
         r_read_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_word     <= w_word;
                  r_st_val   <= ST_Val;
                  r_is_write <= MEM_W_EN;
                  r_cnt      <= '0;
               end
            end
            S_LO: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (!r_is_write) begin
                     r_read_data[15:0] <= SRAM_DQ_in;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_HI: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (!r_is_write) begin
                     r_read_data[31:16] <= SRAM_DQ_in;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stall_ctrl
// Description : Scoreboard bench for mem_stall_ctrl with a half-word SRAM
//               model; a second instance covers SRAM_WAIT=1 idle behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_result;
   logic [31:0] st_val;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   logic [31:0] read_data2;
   logic        ready2;
   logic [17:0] sram_addr2;
   logic [15:0] sram_dq_out2;
   logic        sram_dq_oe2;
   logic        sram_we_n2;

   logic [15:0] mem [0:15];

   typedef struct {
      bit          is_write;
      int          hw;
      logic [31:0] data;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_stall_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(2)) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
      .ALU_result(alu_result), .ST_Val(st_val), .read_data(read_data),
      .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_DQ_out(sram_dq_out),
      .SRAM_DQ_oe(sram_dq_oe), .SRAM_DQ_in(sram_dq_in), .SRAM_WE_N(sram_we_n)
   );

   mem_stall_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(1)) dut2 (
      .clk(clk), .rst(rst), .MEM_R_EN(1'b0), .MEM_W_EN(1'b0),
      .ALU_result(32'd0), .ST_Val(32'd0), .read_data(read_data2),
      .ready(ready2), .SRAM_ADDR(sram_addr2), .SRAM_DQ_out(sram_dq_out2),
      .SRAM_DQ_oe(sram_dq_oe2), .SRAM_DQ_in(16'd0), .SRAM_WE_N(sram_we_n2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Half-word SRAM model: synchronous write, asynchronous read.
   assign sram_dq_in = mem[sram_addr[3:0]];
   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one access and hold the request until the DONE cycle, the way a
   // frozen pipeline would; returns right after the edge that leaves DONE.
   task automatic do_access(input bit r, input bit w, input logic [31:0] addr,
                            input logic [31:0] data, input exp_t e);
      bit seen;
      @(posedge clk); #1;
      mem_r_en   = r;
      mem_w_en   = w;
      alu_result = addr;
      st_val     = data;
      sb.push_back(e);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ready) seen = 1;
      end
      if (!seen) check("access_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
   endtask

   // Monitor: measures the ready-low stretch of each access, checks pins in
   // the SRAM phases and, on the DONE cycle, pops and compares the scoreboard.
   int busy   = 0;
   int lowcnt = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy = 0;
         end else if (busy == 0) begin
            if (!ready) begin
               busy   = 1;
               lowcnt = 1;
            end
         end else if (!ready) begin
            lowcnt++;
            if (sb.size() > 0) begin
               if (sb[0].is_write) begin
                  check("wr_phase_we_n", {31'd0, sram_we_n}, 32'd0);
                  check("wr_phase_oe", {31'd0, sram_dq_oe}, 32'd1);
               end else begin
                  check("rd_phase_we_n", {31'd0, sram_we_n}, 32'd1);
                  check("rd_phase_oe", {31'd0, sram_dq_oe}, 32'd0);
                  check("rd_phase_dq_out", {16'd0, sram_dq_out}, 32'd0);
               end
            end
         end else begin
            busy = 0;
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               // Request cycle in IDLE plus two 2-cycle phases.
               check("ready_low_cycles", lowcnt, 32'd5);
               check("read_data", read_data, e.rd);
               if (e.is_write)
                  check("sram_store", {mem[e.hw+1], mem[e.hw]}, e.data);
               check("done_we_n", {31'd0, sram_we_n}, 32'd1);
               check("done_addr", {14'd0, sram_addr}, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      rst        = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      alu_result = 32'd0;
      st_val     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_addr", {14'd0, sram_addr}, 32'd0);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
      check("rst_read_data", read_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: store 0xDEADBEEF @1028 -> word 1, half-words 2/3
      do_access(0, 1, 32'd1028, 32'hDEADBEEF, '{1, 2, 32'hDEADBEEF, 32'h0});
      check("t1_sram2", {16'd0, mem[2]}, 32'h0000BEEF);
      check("t1_sram3", {16'd0, mem[3]}, 32'h0000DEAD);
      // 2: load back from 1028
      do_access(1, 0, 32'd1028, 32'h0, '{0, 2, 32'hDEADBEEF, 32'hDEADBEEF});
      // 3: both enables -> store 0x12345678 @1024 -> half-words 0/1
      do_access(1, 1, 32'd1024, 32'h12345678, '{1, 0, 32'h12345678, 32'hDEADBEEF});
      check("t3_sram0", {16'd0, mem[0]}, 32'h00005678);
      check("t3_sram1", {16'd0, mem[1]}, 32'h00001234);
      // 4: back-to-back load @1024 then store @1032 (half-words 4/5)
      do_access(1, 0, 32'd1024, 32'h0, '{0, 0, 32'h12345678, 32'h12345678});
      do_access(0, 1, 32'd1032, 32'hCAFEF00D, '{1, 4, 32'hCAFEF00D, 32'h12345678});

      // 5: reset in the HI phase of a store @1036 (word 3)
      @(posedge clk); #1;
      mem_w_en   = 1'b1;
      alu_result = 32'd1036;
      st_val     = 32'h55AA1234;
      repeat (3) @(posedge clk);
      #1;
      check("t5_hi_addr", {14'd0, sram_addr}, 32'd7);
      check("t5_hi_dq_out", {16'd0, sram_dq_out}, 32'h000055AA);
      rst      = 1'b0;
      mem_w_en = 1'b0;
      #1;
      check("t5_ready", {31'd0, ready}, 32'd1);
      check("t5_we_n", {31'd0, sram_we_n}, 32'd1);
      check("t5_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("t5_addr", {14'd0, sram_addr}, 32'd0);
      check("t5_read_data", read_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 6: SRAM_WAIT=1 instance idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t6_ready", {31'd0, ready2}, 32'd1);
         check("t6_addr", {14'd0, sram_addr2}, 32'd0);
         check("t6_we_n", {31'd0, sram_we_n2}, 32'd1);
      end
      check("t6_quiet_pins", {sram_dq_out2, 15'd0, sram_dq_oe2}, 32'd0);
      check("t6_read_data", read_data2, 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
